instr_reg_ctrl: RTL

- Write/read sequencer for the 32-entry instruction register.
- Arbitrates NUM_REQ instruction producers round-robin onto the register's single write port, driving load_en, write_pointer, opcode and operands.
- Manages the register as a circular queue, with read_pointer advanced by a valid/ready consumer handshake.
- Provides occupancy, full and empty status, and a flush sequence.

---
 rtl/instr_reg_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instr_reg_ctrl.sv
// Write/read sequencer for the instruction register.
// Producers are arbitrated round-robin onto the single write port. Each grant
// is registered and presented to the register as a one-cycle load_en strobe.
// The register is managed as a circular queue whose oldest entry is popped by
// a valid/ready consumer. A flush lets any in-flight write land, then clears
// both pointers and the occupancy count.
module instr_reg_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*4-1:0]  req_opcode,
  input  logic [NUM_REQ*32-1:0] req_operand_a,
  input  logic [NUM_REQ*32-1:0] req_operand_b,
  input  logic                  flush,
  output logic                  load_en,
  output logic [3:0]            opcode,
  output logic [31:0]           operand_a,
  output logic [31:0]           operand_b,
  output logic [ADDR_W-1:0]     write_pointer,
  output logic [ADDR_W-1:0]     read_pointer,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [1:0]            grant_id,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  state_t            state, state_next;
  logic [1:0]        last_grant;
  logic [1:0]        grant_idx;
  logic              grant_found;
  logic              can_accept;
  logic              accept;
  logic              pop;
  logic [ADDR_W+1:0] occupancy;

  // Occupancy includes the write still in flight, so a granted entry
  // always has a slot waiting for it.
  assign occupancy = {1'b0, count} + (ADDR_W+2)'(load_en);
  assign full      = (occupancy == DEPTH_W);
  assign empty     = (count == '0);

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int cand;
      logic [NUM_REQ-1:0] shifted;
      cand    = (int'(last_grant) + k) % NUM_REQ;
      shifted = req_valid >> cand;
      if (!grant_found && shifted[0]) begin
        grant_found = 1'b1;
        grant_idx   = 2'(cand);
      end
    end
  end

  // Next-state logic and handshake outputs of the RUN/FLUSH controller.
  always_comb begin
    state_next = state;
    can_accept = 1'b0;
    rd_valid   = 1'b0;
    case (state)
      ST_RUN: begin
        // A flush pulse also blocks the grant in its own cycle so nothing
        // new enters while the queue is being discarded. reset_n gates the
        // grant so req_ready is low for the whole reset.
        can_accept = reset_n && !flush && (occupancy < DEPTH_W);
        rd_valid   = (count != '0);
        if (flush) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Hold here while a write is still landing, then clear and resume.
        if (!load_en) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    req_ready = (grant_found && can_accept) ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  assign accept = grant_found && can_accept;
  assign pop    = rd_valid && rd_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) state <= ST_RUN;
    else          state <= state_next;
  end

  // Write pipeline: register the granted instruction for one load_en cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en    <= 1'b0;
      opcode     <= '0;
      operand_a  <= '0;
      operand_b  <= '0;
      grant_id   <= '0;
      last_grant <= 2'(NUM_REQ - 1);
    end else if (accept) begin
      load_en    <= 1'b1;
      opcode     <= 4'(req_opcode >> (4 * int'(grant_idx)));
      operand_a  <= 32'(req_operand_a >> (32 * int'(grant_idx)));
      operand_b  <= 32'(req_operand_b >> (32 * int'(grant_idx)));
      grant_id   <= grant_idx;
      last_grant <= grant_idx;
    end else begin
      load_en <= 1'b0;
    end
  end

  // Circular-queue pointers and count; the flush clear wins once no write
  // is pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
    end else if (state == ST_FLUSH && !load_en) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
    end else begin
      if (load_en) write_pointer <= write_pointer + 1'b1;
      if (pop)     read_pointer  <= read_pointer + 1'b1;
      case ({load_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
